// File: rtl/stream_fifo_pkg.sv
// stream_pkg: shared defaults, level-width helper and word type for the acquisition stream blocks.
package stream_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 16;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: DEPTH x DATA_WIDTH simple dual-port storage, one write port, synchronous read, no reset.
module stream_fifo_mem
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: show-ahead synchronous FIFO with level status, flush and sticky underflow.
// Define STREAM_FIFO_PEAK_LEVEL_EN to track the peak level since reset or flush.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AFULL_THRESH = 12,
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_read,
  output logic [LVL_W-1:0]      level,
  output logic                  full,
  output logic                  almost_full,
  output logic                  underflow_err,
  output logic [LVL_W-1:0]      peak_level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [DATA_WIDTH-1:0] byp_q, byp_d, mem_rdata;
  logic sel_q, sel_d, err_q, err_d;
  logic push, pop, rd_en, load_byp;
  assign full = level_q == LVL_W'(DEPTH);
  assign almost_full = level_q >= LVL_W'(AFULL_THRESH);
  assign data_in_ready = !full;
  assign data_out_valid = level_q != '0;
  assign level = level_q;
  assign underflow_err = err_q;
  assign push = data_in_valid && data_in_ready && !flush;
  assign pop = data_out_read && data_out_valid && !flush;
  // Every word is written to memory; the head is shown either from the bypass register or the read port.
  assign rd_en = pop && level_q > LVL_W'(1);
  assign load_byp = push && (level_q == '0 || (pop && level_q == LVL_W'(1)));
  assign data_out = sel_q ? byp_q : mem_rdata;
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    level_d = flush ? '0 : level_q + LVL_W'(push) - LVL_W'(pop);
    sel_d = (flush || load_byp) ? 1'b1 : rd_en ? 1'b0 : sel_q;
    byp_d = flush ? '0 : load_byp ? data_in : byp_q;
    err_d = !flush && (err_q || (data_out_read && !data_out_valid));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      sel_q <= 1'b1;
      byp_q <= '0;
      err_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      sel_q <= sel_d;
      byp_q <= byp_d;
      err_q <= err_d;
    end
  end
  stream_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wptr_q),
    .wdata_i(data_in),
    .re_i   (rd_en),
    .raddr_i(rptr_q + AW'(1)),
    .rdata_o(mem_rdata)
  );
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
  logic [LVL_W-1:0] peak_q, peak_d;
  assign peak_d = flush ? '0 : (level_q > peak_q) ? level_q : peak_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) peak_q <= '0;
    else peak_q <= peak_d;
  end
  assign peak_level = peak_q;
`else
  assign peak_level = '0;
`endif
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: random and directed traffic checked against a queue-based reference model.
module tb_stream_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int LW = 5;
  logic clk = 0, rst = 0, flush = 0, data_in_valid = 0, data_out_read = 0;
  logic [DW-1:0] data_in = '0;
  logic data_in_ready, data_out_valid, full, almost_full, underflow_err;
  logic [DW-1:0] data_out;
  logic [LW-1:0] level, peak_level;
  int total = 0, passed = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  int m_peak = 0;
  bit m_err = 0;
  always #5 clk = ~clk;
  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_read(data_out_read), .level(level), .full(full), .almost_full(almost_full),
    .underflow_err(underflow_err), .peak_level(peak_level)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".level"}, 64'(level), 64'(q.size()));
    chk({tag, ".valid"}, 64'(data_out_valid), 64'(q.size() != 0));
    chk({tag, ".ready"}, 64'(data_in_ready), 64'(q.size() != DEPTH));
    chk({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
    chk({tag, ".afull"}, 64'(almost_full), 64'(q.size() >= AF));
    chk({tag, ".uflow"}, 64'(underflow_err), 64'(m_err));
    chk({tag, ".dout"}, 64'(data_out), 64'(m_dout));
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
    chk({tag, ".peak"}, 64'(peak_level), 64'(m_peak));
`else
    chk({tag, ".peak"}, 64'(peak_level), 64'(0));
`endif
  endtask
  task automatic model_reset();
    q.delete();
    m_err = 0;
    m_dout = '0;
    m_peak = 0;
  endtask
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, input bit f, input string tag);
    int sz;
    bit do_push, do_pop;
    data_in_valid = v;
    data_in = d;
    data_out_read = r;
    flush = f;
    sz = q.size();
    do_push = v && sz < DEPTH;
    do_pop = r && sz > 0;
    @(posedge clk);
    if (f) model_reset();
    else begin
      if (sz > m_peak) m_peak = sz;
      if (r && sz == 0) m_err = 1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (q.size() > 0) m_dout = q[0];
    end
    @(negedge clk);
    check_all(tag);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1;
    cycle(1, 32'hA5A5_0001, 0, 0, "first");
    cycle(0, 0, 0, 1, "flush0");
    for (int i = 0; i < 16; i++) cycle(1, DW'(i), 0, 0, "fill");
    cycle(1, 32'hDEAD_BEEF, 0, 0, "over");
    cycle(0, 0, 0, 1, "flush1");
    for (int i = 0; i < 10; i++) cycle(1, $urandom, 0, 0, "push10");
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, "pop10");
    for (int i = 0; i < 16; i++) cycle(1, 32'h100 + DW'(i), 0, 0, "wrapfill");
    cycle(1, 32'hBAD0_0001, 1, 0, "fullpp");
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0, "drain");
    for (int i = 0; i < 5; i++) cycle(1, $urandom, 0, 0, "lvl5");
    for (int i = 0; i < 20; i++) cycle(1, $urandom, 1, 0, "pp5");
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, "drain5");
    cycle(0, 0, 1, 0, "uflow");
    cycle(0, 0, 0, 0, "uflow_hold");
    cycle(1, 32'h77, 0, 0, "lvl1");
    cycle(1, 32'h78, 1, 0, "pp1");
    for (int i = 0; i < 6; i++) cycle(1, $urandom, 0, 0, "lvl7");
    cycle(1, 32'h99, 1, 1, "flush7");
    for (int i = 0; i < 400; i++) begin
      bit v, r;
      v = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(v, $urandom, r, $urandom_range(0, 63) == 0, "rand");
    end
    cycle(0, 0, 0, 1, "flush2");
    for (int i = 0; i < 9; i++) cycle(1, $urandom, 0, 0, "lvl9");
    cycle(0, 0, 0, 0, "idle9");
`ifdef STREAM_FIFO_PEAK_LEVEL_EN
    chk("peak_pre", 64'(peak_level), 64'(9));
`endif
    data_in_valid = 1;
    data_out_read = 1;
    #2 rst = 0;
    #1 model_reset();
    check_all("async_rst");
    data_in_valid = 0;
    data_out_read = 0;
    @(negedge clk);
    check_all("rst_hold");
    rst = 1;
    cycle(1, 32'h1234_5678, 0, 0, "post_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
